// File: rtl/sd_reg_pkg.sv
// rtl/sd_reg_pkg.sv - shared types and constants for the SD host register master
// Contents: master FSM state enum, SD host register indices, rw encodings.
package sd_reg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RELEASE  = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int unsigned ARGUMENT    = 2;
    localparam int unsigned CMD_XFER    = 3;
    localparam int unsigned RESPONSE0   = 4;
    localparam int unsigned INT_STATUS  = 12;
    localparam int unsigned TIMEOUT_REG = 24;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sd_reg_timeout_cnt.sv
// rtl/sd_reg_timeout_cnt.sv - saturating ack-timeout counter with clear/enable
// Ports: clk, reset (async, active-high), clear (sync zero), enable (count up),
//        expire (count has reached LIMIT-1; the counter holds there).
module sd_reg_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/sd_reg_master.sv
// rtl/sd_reg_master.sv - four-phase bus initiator for the SD host register file
// Ports: clk, reset (async, active-high);
//        command in:  cmd_valid/cmd_ready, cmd_rw, cmd_addr, cmd_wdata,
//                     cmd_poll, cmd_mask, cmd_match;
//        response:    rsp_valid (1-cycle pulse), rsp_rdata, rsp_error;
//        reg file:    reg_req, reg_rw, reg_addr, reg_wdata, reg_rdata, reg_ack.
// Option: SD_REG_MASTER_POLL_EN enables read polling until (rdata & mask) == match.
module sd_reg_master
    import sd_reg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ACK_TIMEOUT = 16,
    parameter int POLL_MAX    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_poll,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic [DATA_W-1:0] cmd_match,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              reg_req,
    output logic              reg_rw,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack
);

    state_t            state;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              expire;

`ifdef SD_REG_MASTER_POLL_EN
    localparam int PW = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
    logic              poll_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] match_q;
    logic [PW-1:0]     poll_cnt;
`else
    logic unused_poll;
    assign unused_poll = ^{cmd_poll, cmd_mask, cmd_match};
`endif

    // Counter runs only while waiting for ack; every other state holds it at
    // zero, so a poll re-issue from RELEASE starts with a fresh budget.
    sd_reg_timeout_cnt #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != WAIT_ACK),
        .enable (state == WAIT_ACK),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            reg_req   <= 1'b0;
            reg_rw    <= RW_WRITE;
            reg_addr  <= '0;
            reg_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef SD_REG_MASTER_POLL_EN
            poll_q    <= 1'b0;
            mask_q    <= '0;
            match_q   <= '0;
            poll_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready is registered, so the first IDLE cycle after
                    // reset only raises it; acceptance needs it already high.
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        reg_rw    <= cmd_rw;
                        reg_addr  <= cmd_addr;
                        reg_wdata <= cmd_wdata;
                        reg_req   <= 1'b1;
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
`ifdef SD_REG_MASTER_POLL_EN
                        poll_q    <= cmd_poll;
                        mask_q    <= cmd_mask;
                        match_q   <= cmd_match;
                        poll_cnt  <= '0;
`endif
                        state     <= WAIT_ACK;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Ack is tested first so an ack landing on the last
                    // budget cycle still counts as success.
                    if (reg_ack) begin
                        if (reg_rw == RW_READ) begin
                            rdata_q <= reg_rdata;
                        end
                        reg_req <= 1'b0;
                        state   <= RELEASE;
                    end else if (expire) begin
                        reg_req <= 1'b0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!reg_ack) begin
`ifdef SD_REG_MASTER_POLL_EN
                        if (poll_q && (reg_rw == RW_READ) && !err_q &&
                            ((rdata_q & mask_q) != match_q)) begin
                            if (poll_cnt != PW'(POLL_MAX)) begin
                                poll_cnt <= poll_cnt + 1'b1;
                                reg_req  <= 1'b1;
                                state    <= WAIT_ACK;
                            end else begin
                                err_q <= 1'b1;
                                state <= RESP;
                            end
                        end else begin
                            state <= RESP;
                        end
`else
                        state <= RESP;
`endif
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rdata_q;
                    rsp_error <= err_q;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_reg_master.sv
// tb/tb_sd_reg_master.sv - self-checking bench for sd_reg_master with a register file model
module tb_sd_reg_master;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int ACK_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_poll = 1'b0;
    logic [DATA_W-1:0] cmd_mask = '0;
    logic [DATA_W-1:0] cmd_match = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              reg_req;
    logic              reg_rw;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata = '0;
    logic              reg_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // register file model controls (written only by the stimulus process)
    int   ack_delay  = 1;
    logic no_ack     = 1'b0;
    int   set_thresh = 0;

    // register file model state (written only by the model process)
    logic [DATA_W-1:0] rf_mem [32] = '{default: '0};
    int hold    = 0;
    int reads12 = 0;

    // reference contents seen from the command side
    logic [DATA_W-1:0] ref_mem [32];

    sd_reg_master #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .POLL_MAX    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_poll  (cmd_poll),
        .cmd_mask  (cmd_mask),
        .cmd_match (cmd_match),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .reg_req   (reg_req),
        .reg_rw    (reg_rw),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    always #5 clk = ~clk;

    // Register file: registered ack raised ack_delay edges after req is seen,
    // held while req stays high, dropped one edge after req falls.
    always @(posedge clk) begin
        if (reg_req) begin
            if (!no_ack && (hold >= ack_delay - 1)) begin
                if (!reg_ack && reg_rw) begin
                    reg_rdata <= rf_mem[reg_addr] |
                        {31'd0, (reg_addr == 5'd12) && (set_thresh != 0) && (reads12 + 1 >= set_thresh)};
                    if (reg_addr == 5'd12) reads12 <= reads12 + 1;
                end
                if (!reg_rw) rf_mem[reg_addr] <= reg_wdata;
                reg_ack <= 1'b1;
            end
            hold <= hold + 1;
        end else begin
            reg_ack <= 1'b0;
            hold    <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command and observe it until rsp_valid (bounded).
    // lat = cycles from the accepting edge to the rsp_valid edge.
    task automatic run_cmd(
        input  logic        rw,
        input  logic [4:0]  addr,
        input  logic [31:0] wdata,
        input  logic        poll,
        input  logic [31:0] mask,
        input  logic [31:0] match,
        input  int          d,
        input  logic        hold_valid,
        output logic [31:0] rdata,
        output logic        err,
        output int          lat,
        output int          reqcyc,
        output int          pulses,
        output logic        addr_ok,
        output logic        ready_ok,
        output logic        one_shot
    );
        int   guard;
        int   k;
        logic prev;
        ack_delay = (d == 0) ? 1 : d;
        no_ack    = (d == 0);
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) check("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_poll  = poll;
        cmd_mask  = mask;
        cmd_match = match;
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) begin
            cmd_addr  = addr ^ 5'h1F;
            cmd_wdata = $urandom;
            cmd_rw    = ~rw;
        end else begin
            cmd_valid = 1'b0;
        end
        k = 0; reqcyc = 0; pulses = 0; prev = 1'b0; addr_ok = 1'b1;
        while (k < 200) begin
            if (reg_req) reqcyc++;
            if (reg_req && !prev) pulses++;
            prev = reg_req;
            if (reg_addr != addr || reg_rw != rw) addr_ok = 1'b0;
            if (rsp_valid) break;
            k++;
            @(negedge clk);
        end
        lat      = k;
        rdata    = rsp_rdata;
        err      = rsp_error;
        ready_ok = cmd_ready;
        cmd_valid = 1'b0;
        @(negedge clk);
        one_shot = !rsp_valid;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err, addr_ok, ready_ok, one_shot, saw_rsp;
        int          lat, reqcyc, pulses;
        logic        rw, hv, pl;
        logic [4:0]  addr;
        logic [31:0] wdata, exp_rdata;
        int          d;

        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // reset state
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_reg_req",   32'(reg_req),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata,      32'd0);
        check("rst_reg_addr",  32'(reg_addr),  32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // write ARGUMENT, nominal timing
        run_cmd(1'b0, 5'd2, 32'h1234_5678, 1'b0, 0, 0, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        ref_mem[2] = 32'h1234_5678;
        check("wr2_reqcyc", 32'(reqcyc), 32'd2);
        check("wr2_lat",    32'(lat),    32'd5);
        check("wr2_err",    32'(err),    32'd0);
        check("wr2_rdata",  rdata,       32'd0);
        check("wr2_ready",  32'(ready_ok), 32'd1);
        check("wr2_oneshot", 32'(one_shot), 32'd1);

        run_cmd(1'b1, 5'd2, 0, 1'b0, 0, 0, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("rd2_rdata", rdata, 32'h1234_5678);
        check("rd2_err",   32'(err), 32'd0);

        // preload INT_STATUS and read it, with cmd_valid held (must be ignored)
        run_cmd(1'b0, 5'd12, 32'h1, 1'b0, 0, 0, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        ref_mem[12] = 32'h1;
        run_cmd(1'b1, 5'd12, 0, 1'b0, 0, 0, 1, 1'b1,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("rd12_rdata",  rdata, 32'h1);
        check("rd12_err",    32'(err), 32'd0);
        check("rd12_stable", 32'(addr_ok), 32'd1);
        check("rd12_pulses", 32'(pulses), 32'd1);

        // slave never acks
        run_cmd(1'b1, 5'd12, 0, 1'b0, 0, 0, 0, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("to_reqcyc", 32'(reqcyc), 32'(ACK_TIMEOUT));
        check("to_err",    32'(err),    32'd1);
        check("to_rdata",  rdata,       32'd0);

        // ack on the last budget cycle wins
        run_cmd(1'b1, 5'd2, 0, 1'b0, 0, 0, ACK_TIMEOUT - 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("edge_err",   32'(err), 32'd0);
        check("edge_rdata", rdata,    32'h1234_5678);

        // randomized commands against the reference memory
        for (int n = 0; n < 30; n++) begin
            rw    = 1'($urandom_range(0, 1));
            addr  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            hv    = 1'($urandom_range(0, 1));
            pl    = rw ? 1'b0 : 1'($urandom_range(0, 1));
            d     = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, ACK_TIMEOUT - 1));
            run_cmd(rw, addr, wdata, pl, $urandom, $urandom, d, hv,
                    rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
            if (d == 0) begin
                exp_rdata = 0;
                check("rnd_err",    32'(err),    32'd1);
                check("rnd_lat",    32'(lat),    32'(ACK_TIMEOUT + 2));
                check("rnd_reqcyc", 32'(reqcyc), 32'(ACK_TIMEOUT));
            end else begin
                exp_rdata = rw ? ref_mem[addr] : 32'd0;
                if (!rw) ref_mem[addr] = wdata;
                check("rnd_err",    32'(err),    32'd0);
                check("rnd_lat",    32'(lat),    32'(d + 4));
                check("rnd_reqcyc", 32'(reqcyc), 32'(d + 1));
            end
            check("rnd_rdata",  rdata,          exp_rdata);
            check("rnd_stable", 32'(addr_ok),   32'd1);
            check("rnd_ready",  32'(ready_ok),  32'd1);
            check("rnd_pulses", 32'(pulses),    32'd1);
        end

        // asynchronous reset while waiting for ack
        no_ack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 5'd3; cmd_poll = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ar_req_before", 32'(reg_req), 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_req_async", 32'(reg_req),   32'd0);
        check("ar_ready",     32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("ar_no_rsp", 32'(saw_rsp), 32'd0);
        run_cmd(1'b1, 5'd2, 0, 1'b0, 0, 0, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("ar_next_rdata", rdata, ref_mem[2]);
        check("ar_next_lat",   32'(lat), 32'd5);

`ifdef SD_REG_MASTER_POLL_EN
        run_cmd(1'b0, 5'd12, 32'h0, 1'b0, 0, 0, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        ref_mem[12] = 32'h0;
        set_thresh = reads12 + 3;
        run_cmd(1'b1, 5'd12, 0, 1'b1, 32'h1, 32'h1, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("poll_hit_pulses", 32'(pulses), 32'd3);
        check("poll_hit_err",    32'(err),    32'd0);
        check("poll_hit_rdata",  rdata,       32'h1);
        set_thresh = 0;
        run_cmd(1'b1, 5'd12, 0, 1'b1, 32'h1, 32'h1, 1, 1'b0,
                rdata, err, lat, reqcyc, pulses, addr_ok, ready_ok, one_shot);
        check("poll_miss_pulses", 32'(pulses), 32'd3);
        check("poll_miss_err",    32'(err),    32'd1);
        check("poll_miss_rdata",  rdata,       32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_reg_master.md
Name: sd_reg_master

Overview:
- Bus initiator for the SD host register file's CPU-side port (req/rw/addr/data_in/data_out/ack).
- Accepts one register command at a time from a local valid/ready interface and runs the four-phase handshake: req up, wait ack, req down, wait ack low.
- Returns read data or a timeout error.
- Used by the host-side command sequencer to program Argument/Command (addr 2, 3) and to read status (addr 12).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- ACK_TIMEOUT, 16, maximum cycles in WAIT_ACK before the command is aborted; minimum 2
- POLL_MAX, 255, maximum extra reads in poll mode (only used with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  1 = read, 0 = write (same encoding as the register file)
- cmd_addr  in  ADDR_W  register index
- cmd_wdata  in  DATA_W  write data
- cmd_poll  in  1  poll-mode request (ignored without the macro)
- cmd_mask  in  DATA_W  poll compare mask
- cmd_match  in  DATA_W  poll compare value
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  DATA_W  captured read data; 0 for writes and on error
- rsp_error  out  1  ack timeout, or poll exhausted; qualified by rsp_valid
- reg_req  out  1  to register file req
- reg_rw  out  1  to register file rw
- reg_addr  out  ADDR_W  to register file addr
- reg_wdata  out  DATA_W  to register file data_in
- reg_rdata  in  DATA_W  from register file data_out
- reg_ack  in  1  from register file ack

Behaviour:
- Interface: single clock clk; reset is asynchronous, active-high.
- All outputs are registered. Reset values: all outputs 0, cmd_ready 0 while reset is asserted and 1 in IDLE afterwards; state goes to IDLE.
- FSM states: IDLE, WAIT_ACK, RELEASE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch rw/addr/wdata/poll/mask/match into reg_rw/reg_addr/reg_wdata and shadow registers.
  - Set reg_req=1, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - Counter increments every cycle.
  - On reg_ack=1: capture reg_rdata if rw=1, drop reg_req, go to RELEASE.
  - On counter==ACK_TIMEOUT-1 with no ack: drop reg_req, set err flag, go to RELEASE.
  - Ack takes priority if both occur in the same cycle.
- RELEASE: wait for reg_ack=0, then go to RESP. Guarantees no stale ack is seen by the next command.
- RESP: rsp_valid=1 for exactly one cycle with rdata and error, then go to IDLE.
- Nominal latency against the register file (registered ack): req rises at edge t, ack at t+1, master samples it at t+2, ack low at t+3, rsp_valid at t+5. Command-to-command gap is 6 cycles.
- The register file repeats the write while req is held; this is harmless and accepted.
- reg_rw, reg_addr and reg_wdata are held stable from req rise until the return to IDLE.
- cmd_valid outside IDLE is ignored (not queued).
- Reset mid-transaction: reg_req falls immediately (asynchronously), and no rsp_valid is generated for the aborted command.
- Timeout with the slave still acking afterwards: RELEASE waits indefinitely for ack low.

Optional Feature:
- Macro: SD_REG_MASTER_POLL_EN.
- Defined:
  - A read with cmd_poll=1 re-issues the read after RELEASE while (rdata & cmd_mask) != cmd_match, up to POLL_MAX extra reads.
  - It responds on match, or with rsp_error=1 and the last rdata when retries are exhausted.
  - A timeout on any read ends the poll with an error.
  - Poll on a write is treated as a plain write.
- Undefined: cmd_poll, cmd_mask and cmd_match are unused and the poll counter is not built; ports remain for a uniform interface.

Decomposition:
- Shared package sd_reg_pkg holds:
  - the state enum
  - register index constants: ARGUMENT=2, CMD_XFER=3, RESPONSE0=4, INT_STATUS=12, TIMEOUT_REG=24
  - the RW_READ=1 and RW_WRITE=0 constants
- One sub-module is natural: sd_reg_timeout_cnt, a saturating counter with clear/enable and an expire flag at ACK_TIMEOUT-1.

Test Plan:
- Write addr 2, data 0x1234_5678, against the register file model → reg_req high 2 cycles, rsp_valid at t+5, rsp_error=0; a later read of addr 2 returns 0x1234_5678.
- Read addr 12 preloaded with 0x0000_0001 → rsp_rdata=0x0000_0001, rsp_error=0; reg_addr stable throughout.
- Slave never acks, ACK_TIMEOUT=16 → reg_req drops after 16 cycles, rsp_valid with rsp_error=1 and rsp_rdata=0.
- Ack and timeout in the same cycle (ack delayed 15 cycles) → treated as success, rsp_error=0.
- Async reset asserted in WAIT_ACK → reg_req=0 within the same cycle, no rsp_valid; next command completes normally.
- POLL_EN defined: poll addr 12, mask 0x1, match 0x1, bit set on the 3rd read → 3 req pulses, rsp_error=0. With POLL_MAX=2 and the bit never set → 3 reads, then rsp_error=1.
